// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one outstanding imem read, tagged-instruction FIFO
// toward IF/ID, and the PC-hold signal for the IF PC register.
module if_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        fetch_stall_o,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     req_pc;
  logic [31:0]     buf_data [DEPTH];
  logic [31:0]     buf_pc   [DEPTH];
  logic            push, pop, room, hs;

  assign inst_valid_o  = (count != '0);
  assign inst_o        = inst_valid_o ? buf_data[rd_ptr] : NOP_INST;
  assign inst_pc_o     = inst_valid_o ? buf_pc[rd_ptr]   : '0;
  assign imem_req_addr = pc_i;

  assign pop     = inst_valid_o & ~stall_i & ~flush_i;
  assign push    = (state == S_WAIT) & imem_rsp_valid & ~flush_i;
  assign count_n = count + CW'(push) - CW'(pop);
  assign room    = (count_n < CW'(DEPTH));
  assign hs      = imem_req_valid & imem_req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (hs) state_n = S_WAIT;
      S_WAIT: begin
        if (flush_i)             state_n = imem_rsp_valid ? S_IDLE : S_DRAIN;
        else if (hs)             state_n = S_WAIT;
        else if (imem_rsp_valid) state_n = S_IDLE;
      end
      S_DRAIN: if (!flush_i && imem_rsp_valid) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs; gated by rst_n so the request drops as soon as reset asserts
  always_comb begin
    imem_req_valid = rst_n & room & ~flush_i &
                     ((state == S_IDLE) | ((state == S_WAIT) & imem_rsp_valid));
    fetch_stall_o  = ~(imem_req_valid & imem_req_ready) & ~flush_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_pc <= '0;
    end else begin
      if (hs) req_pc <= pc_i;
      if (flush_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_n;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage RV32I pipeline. It consumes the PC held by the IF-stage PC register and issues one read at a time to instruction memory over a valid/ready request and valid response interface.
- It buffers returned instructions, each tagged with its PC, in a small FIFO that feeds the IF/ID boundary.
- It drives fetch_stall_o, which goes into the PC register's bubble input. The PC advances only when a fetch request is accepted.

Parameters:
- DEPTH, 2, number of instruction-buffer entries (power of two, at least 2).
- NOP_INST, 32'h00000013, value driven on inst_o when the buffer is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_i  in  32  current fetch PC from the IF PC register.
- flush_i  in  1  redirect/flush from the hazard unit (branch taken, jump).
- stall_i  in  1  the ID stage cannot accept an instruction this cycle.
- fetch_stall_o  out  1  to bubbleF; 1 means the PC register must hold.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; equals pc_i.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response data valid; at most one response per accepted request.
- imem_rsp_data  in  32  instruction word.
- inst_valid_o  out  1  buffer head is valid.
- inst_o  out  32  head instruction, or NOP_INST when the buffer is empty.
- inst_pc_o  out  32  PC of the head instruction, or 0 when the buffer is empty.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, buffer count=0, req_pc=0.
  - Outputs: imem_req_valid=0, inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=0, fetch_stall_o=1.
  - Reset mid-transaction abandons any outstanding request. A response arriving after reset, while in IDLE, is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request accepted, response pending.
  - DRAIN: a flush occurred while a response was pending; the next response is discarded.
- Pop: occurs when inst_valid_o=1, stall_i=0 and flush_i=0. It takes effect at the next clock edge. The head is presented combinationally from the FIFO.
- Push: occurs in WAIT when imem_rsp_valid=1 and flush_i=0. The entry written is {req_pc, imem_rsp_data}.
- Next count: count_n = count + push - pop. room = (count_n < DEPTH).
- Request issue: imem_req_valid = room & !flush_i & (state==IDLE | (state==WAIT & imem_rsp_valid)).
  - Back-to-back issue in the response cycle is allowed, giving 1 instruction per cycle with a 1-cycle memory.
  - imem_req_valid may depend combinationally on imem_rsp_valid and stall_i. Neither may depend combinationally on imem_req_valid.
- On request handshake (imem_req_valid & imem_req_ready): req_pc <= pc_i, state <= WAIT.
- WAIT, imem_rsp_valid, no new handshake: state <= IDLE.
- DRAIN:
  - imem_rsp_valid → discard the data, state <= IDLE. No request is issued in this cycle.
  - flush_i in DRAIN keeps the state in DRAIN.
- fetch_stall_o = !(imem_req_valid & imem_req_ready) & !flush_i.
  - It is forced to 0 during flush_i so the PC register can take the flush or redirect.
  - The PC advances exactly once per accepted request.
- flush_i=1:
  - The buffer is cleared (count <= 0) and no push or pop occurs.
  - WAIT without imem_rsp_valid → DRAIN.
  - WAIT with imem_rsp_valid in the same cycle → the response is discarded, state <= IDLE.
  - IDLE stays IDLE.
- Full buffer: no request is issued. A simultaneous pop and push at count=DEPTH-1 is legal; room is computed from count_n.
- Response received in IDLE: this is a protocol violation; it is ignored and the state is unchanged.
- Request is held stable: once imem_req_valid=1 and ready=0, the address is held because fetch_stall_o=1 freezes pc_i. This holds unless flush_i deasserts the request.

Test Plan:
- Reset then release, memory with ready=1 and response 1 cycle later with data=addr+0x100, stall_i=0.
  - Required: requests to 0x0, 0x4, 0x8 on consecutive cycles after the first response.
  - Required: inst_o/inst_pc_o sequence 0x100/0x0, 0x104/0x4, 0x108/0x8.
  - Required: fetch_stall_o=0 on every handshake cycle.
- Hold stall_i=1 with DEPTH=2.
  - Required: after 2 pushes, imem_req_valid=0 and fetch_stall_o=1.
  - Then release stall_i=0. Required: pops proceed, and a new request is issued in the same cycle count_n drops below 2.
- Hold imem_req_ready=0 for 3 cycles with pc_i=0x20.
  - Required: imem_req_valid=1 and addr=0x20 held throughout, fetch_stall_o=1.
  - On ready=1: one handshake and req_pc=0x20.
- Assert flush_i 1 cycle after request 0x40 is accepted, with the response arriving 3 cycles later.
  - Required: buffer empty (inst_o=0x00000013), state DRAIN, stale response discarded.
  - Required: the next request uses the new pc_i.
- Assert flush_i in the same cycle as imem_rsp_valid.
  - Required: response not pushed, no request that cycle, IDLE next cycle.
- Drop rst_n asynchronously while in WAIT, then inject a stray imem_rsp_valid after release.
  - Required: outputs return immediately to reset values, and the stray response is ignored.
